led_scan_driver: RTL and testbench
==================================

# led_scan_driver

Multiplexed seven-segment display driver that sits directly downstream of the LED-showing RAM. It walks the RAM's eight byte-wide display slots in order, drives the RAM read address, and captures the returned byte. It decodes the byte to active-low segment patterns and time-multiplexes the board's common-anode digits, with a guard interval between digits to suppress ghosting.

## Interface
- NUM_DIGITS, 8, number of scanned digits / RAM slots (1..8)
- REFRESH_DIV, 50000, clock cycles each digit is lit (≥1)
- GUARD_CYCLES, 16, clock cycles all digits are off between digits (≥0; 0 = no guard)

- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  scan enable; low blanks the display and holds the scanner idle
- read_address  output  3  slot address to the RAM read port
- read_data  input  8  byte from the RAM read port (combinational w.r.t. read_address)
- digit_sel  output  NUM_DIGITS  active-low digit enables (one-hot-low while lit)
- segments  output  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}
- frame_done  output  1  one-cycle pulse at the end of each complete scan frame

One clock; reset is synchronous and active-high.

## Operation
- Byte format: [3:0] hex value, [4] decimal point on, [6:5] ignored, [7] blank digit.
- Decode (active-low, dp bit excluded): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. segments[7] = ~byte[4]. If byte[7]=1, segments = FF, and the digit is still selected.
- State machine: IDLE, FETCH, SHOW, GUARD.
  - IDLE: digit_sel all ones, segments FF, digit index 0. Go to FETCH when enable=1.
  - FETCH: lasts 1 cycle with read_address = digit index, and digits stay off. At the closing edge, read_data is captured into the display register. Go to SHOW.
  - SHOW: lasts REFRESH_DIV cycles. digit_sel[index]=0, all others 1, and segments come from the captured byte. Go to GUARD, or directly to advance if GUARD_CYCLES=0.
  - GUARD: lasts GUARD_CYCLES cycles with all digits off and segments FF. Then advance.
  - Advance: index = index+1. At index NUM_DIGITS-1 it wraps to 0 and frame_done pulses. Go to FETCH.
- read_address is registered and equals the digit index in every state. It is 0 in IDLE.
- Captured byte is held for the whole SHOW. RAM writes during SHOW take effect at that slot's next FETCH.
- Internal divide counter is wide enough for max(REFRESH_DIV, GUARD_CYCLES) and resets to 0 on each state entry.

## Timing
- Reset values: read_address 0, digit_sel all ones, segments FF, frame_done 0, state IDLE, index 0, counter 0. Reset has priority over enable.
- After reset is released with enable=1, the first cycle is IDLE→FETCH, and digit 0 lights 2 cycles after the first enable-high edge is sampled.
- Digit period = 1 + REFRESH_DIV + GUARD_CYCLES cycles. Frame period = NUM_DIGITS × digit period.
- frame_done is asserted on the last cycle of digit NUM_DIGITS-1 (last GUARD cycle, or last SHOW cycle if GUARD_CYCLES=0). It is exactly 1 cycle wide.
- enable low in any state: the next cycle is IDLE with outputs blanked and index 0, and no frame_done. Re-enabling restarts at digit 0.
- reset mid-frame: outputs return to reset values at the next edge and no frame_done is produced.
- NUM_DIGITS=1: the index stays 0 and frame_done pulses every digit period.
- digit_sel and segments are registered and glitch-free. At most one digit_sel bit is low in any cycle.

## Test plan
- Reset then enable with RAM slots 0..7 = 00..07, REFRESH_DIV=4, GUARD_CYCLES=2 -> read_address steps 0..7, digit_sel steps FE, FD, … 7F with segments C0, F9, A4, B0, 99, 92, 82, F8. Each digit is lit 4 cycles with 2 blank cycles between. frame_done pulses every 56 cycles.
- Slot 3 = 1A, slot 5 = 8E -> digit 3 shows segments 08 (A with dp). Digit 5 shows FF with digit_sel = DF.
- GUARD_CYCLES=0, REFRESH_DIV=1 -> digit period is 2 cycles, no all-off cycle except FETCH. frame_done pulses every 16 cycles.
- Deassert enable during SHOW of digit 4 -> next cycle digit_sel FF, segments FF, read_address 0, no frame_done. On re-enable, the first lit digit is 0.
- Assert reset mid-GUARD of digit 7 -> no frame_done pulse, all outputs at reset values the next cycle.
- Write slot 2 from 00 to 0F while digit 2 is in SHOW -> segments stay C0 until the next frame's FETCH of slot 2, then show 8E.

Source files
------------

// File: rtl/led_scan_driver.sv
// led_scan_driver
//   Multiplexed seven-segment driver placed directly after the LED-showing RAM.
//   Walks the RAM display slots in order, fetches each byte, decodes it to
//   active-low segments and lights one common-anode digit at a time, with an
//   all-off guard interval between digits to suppress ghosting.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       scan enable; low blanks the display and parks the scanner
//   read_address slot address to the RAM read port (registered, = digit index)
//   read_data    RAM byte: [3:0] hex, [4] dp on, [6:5] ignored, [7] blank
//   digit_sel    active-low digit enables, at most one low at a time
//   segments     active-low segments {dp,g,f,e,d,c,b,a}
//   frame_done   one-cycle pulse on the last cycle of the last digit
//
// States
//   IDLE  | display blank, index 0, waiting for enable
//   FETCH | one cycle, read_address = index, RAM byte captured at its end
//   SHOW  | REFRESH_DIV cycles, selected digit lit with captured pattern
//   GUARD | GUARD_CYCLES cycles, all digits off before advancing

module led_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [2:0]            read_address,
  input  logic [7:0]            read_data,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [7:0]            segments,
  output logic                  frame_done
);

  localparam int MAX_CNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = '1;

  typedef enum logic [1:0] {IDLE, FETCH, SHOW, GUARD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_digit;
  logic [2:0]    next_address;
  logic          unused_bits;

  assign last_digit   = (int'(read_address) == NUM_DIGITS - 1);
  assign next_address = last_digit ? 3'd0 : read_address + 3'd1;
  assign unused_bits  = ^read_data[6:5];

  // Blank bit overrides everything, including the decimal point.
  function automatic logic [7:0] decode(input logic [7:0] b);
    logic [6:0] s;
    case (b[3:0])
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return b[7] ? 8'hFF : {~b[4], s};
  endfunction

  // read_address doubles as the digit index. frame_done is raised on the edge
  // that enters the final cycle of the last digit, so each branch predicts
  // whether the cycle it is entering is that one.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state        <= IDLE;
      cnt          <= '0;
      read_address <= 3'd0;
      digit_sel    <= ALL_OFF;
      segments     <= 8'hFF;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          state <= FETCH;
          cnt   <= '0;
        end
        FETCH: begin
          state      <= SHOW;
          cnt        <= '0;
          digit_sel  <= ~(NUM_DIGITS'(1) << read_address);
          segments   <= decode(read_data);
          frame_done <= last_digit && (GUARD_CYCLES == 0) && (REFRESH_DIV == 1);
        end
        SHOW: begin
          if (int'(cnt) == REFRESH_DIV - 1) begin
            cnt       <= '0;
            digit_sel <= ALL_OFF;
            segments  <= 8'hFF;
            if (GUARD_CYCLES == 0) begin
              state        <= FETCH;
              read_address <= next_address;
            end else begin
              state      <= GUARD;
              frame_done <= last_digit && (GUARD_CYCLES == 1);
            end
          end else begin
            cnt        <= cnt + 1'b1;
            frame_done <= last_digit && (GUARD_CYCLES == 0) &&
                          (int'(cnt) == REFRESH_DIV - 2);
          end
        end
        GUARD: begin
          if (int'(cnt) == GUARD_CYCLES - 1) begin
            state        <= FETCH;
            cnt          <= '0;
            read_address <= next_address;
          end else begin
            cnt        <= cnt + 1'b1;
            frame_done <= last_digit && (int'(cnt) == GUARD_CYCLES - 2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// tb_led_scan_driver
//   Three driver instances with different timing parameters share one RAM
//   image. A timeline model (cycle position within the frame) predicts every
//   cycle's outputs into a queue; a monitor pops and compares on the falling
//   edge.

module tb_led_scan_driver;

  localparam int N0 = 8, R0 = 4, G0 = 2;
  localparam int N1 = 8, R1 = 1, G1 = 0;
  localparam int N2 = 1, R2 = 3, G2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable;
  logic [7:0] ram [8];

  logic [2:0]    ra0, ra1, ra2;
  logic [7:0]    rd0, rd1, rd2;
  logic [N0-1:0] sel0;
  logic [N1-1:0] sel1;
  logic [N2-1:0] sel2;
  logic [7:0]    seg0, seg1, seg2;
  logic          fd0, fd1, fd2;

  assign rd0 = ram[ra0];
  assign rd1 = ram[ra1];
  assign rd2 = ram[ra2];

  led_scan_driver #(.NUM_DIGITS(N0), .REFRESH_DIV(R0), .GUARD_CYCLES(G0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .read_address(ra0),
    .read_data(rd0), .digit_sel(sel0), .segments(seg0), .frame_done(fd0));
  led_scan_driver #(.NUM_DIGITS(N1), .REFRESH_DIV(R1), .GUARD_CYCLES(G1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .read_address(ra1),
    .read_data(rd1), .digit_sel(sel1), .segments(seg1), .frame_done(fd1));
  led_scan_driver #(.NUM_DIGITS(N2), .REFRESH_DIV(R2), .GUARD_CYCLES(G2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .read_address(ra2),
    .read_data(rd2), .digit_sel(sel2), .segments(seg2), .frame_done(fd2));

  typedef struct {
    int          cyc;
    logic [8:0]  addr;
    logic [23:0] sel;
    logic [23:0] seg;
    logic [2:0]  fd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  int         nd [3];
  int         rdv[3];
  int         gd [3];
  int         t  [3];
  logic [7:0] cap[3];
  logic [7:0] hex_tab[16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] seg_of(input logic [7:0] b);
    logic [7:0] h;
    h = hex_tab[b[3:0]];
    return b[7] ? 8'hFF : {~b[4], h[6:0]};
  endfunction

  // t = cycles since the first FETCH of the current run, -1 while idle.
  // Within a digit period P: offset 0 is fetch, 1..R lit, the rest guard.
  task automatic step(input logic rst, input logic en);
    exp_t e;
    reset  = rst;
    enable = en;
    e.cyc  = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      int p, d, off;
      logic [7:0] mask, a_sel, a_seg;
      logic [2:0] a_addr;
      logic       a_fd, lit;
      p    = 1 + rdv[i] + gd[i];
      mask = 8'((1 << nd[i]) - 1);
      if (rst || !en) t[i] = -1;
      else            t[i] = t[i] + 1;
      if (t[i] < 0) begin
        a_addr = 3'd0; a_sel = mask; a_seg = 8'hFF; a_fd = 1'b0;
      end else begin
        d   = (t[i] / p) % nd[i];
        off = t[i] % p;
        if (off == 1) cap[i] = ram[d];
        lit    = (off >= 1) && (off <= rdv[i]);
        a_addr = 3'(d);
        a_sel  = lit ? (mask & ~8'(1 << d)) : mask;
        a_seg  = lit ? seg_of(cap[i]) : 8'hFF;
        a_fd   = (d == nd[i] - 1) && (off == p - 1);
      end
      e.addr[i*3 +: 3] = a_addr;
      e.sel[i*8 +: 8]  = a_sel;
      e.seg[i*8 +: 8]  = a_seg;
      e.fd[i]          = a_fd;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Runs instance 0 until its current cycle sits at (digit, offset).
  task automatic wait_for(input int d, input int off);
    bit found;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (t[0] >= 0 && ((t[0] / 7) % 8) == d && (t[0] % 7) == off) found = 1;
      else step(1'b0, 1'b1);
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL wait_for digit %0d offset %0d: not reached, required within 200 cycles", d, off);
    end
  endtask

  task automatic chk(input string nm, input int inst, input logic [7:0] act, input logic [7:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s[%0d] cyc %0d: got %h expected %h", nm, inst, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      chk("read_address", 0, {5'd0, ra0}, {5'd0, mon_e.addr[2:0]});
      chk("read_address", 1, {5'd0, ra1}, {5'd0, mon_e.addr[5:3]});
      chk("read_address", 2, {5'd0, ra2}, {5'd0, mon_e.addr[8:6]});
      chk("digit_sel", 0, 8'(sel0), mon_e.sel[7:0]);
      chk("digit_sel", 1, 8'(sel1), mon_e.sel[15:8]);
      chk("digit_sel", 2, 8'(sel2), mon_e.sel[23:16]);
      chk("segments", 0, seg0, mon_e.seg[7:0]);
      chk("segments", 1, seg1, mon_e.seg[15:8]);
      chk("segments", 2, seg2, mon_e.seg[23:16]);
      chk("frame_done", 0, {7'd0, fd0}, {7'd0, mon_e.fd[0]});
      chk("frame_done", 1, {7'd0, fd1}, {7'd0, mon_e.fd[1]});
      chk("frame_done", 2, {7'd0, fd2}, {7'd0, mon_e.fd[2]});
    end
  end

  initial begin
    int slot;
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    nd  = '{N0, N1, N2};
    rdv = '{R0, R1, R2};
    gd  = '{G0, G1, G2};
    for (int i = 0; i < 3; i++) begin
      t[i]   = -1;
      cap[i] = 8'h00;
    end
    for (int i = 0; i < 8; i++) ram[i] = 8'(i);

    repeat (3) step(1'b1, 1'b0);
    repeat (2 * 56 + 4) step(1'b0, 1'b1);

    ram[3] = 8'h1A;
    ram[5] = 8'h8E;
    repeat (60) step(1'b0, 1'b1);

    wait_for(4, 2);
    ram[2] = 8'h00;
    step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);

    wait_for(2, 2);
    ram[2] = 8'h0F;
    repeat (60) step(1'b0, 1'b1);

    wait_for(7, 5);
    step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);

    repeat (800) begin
      if ($urandom_range(5) == 0) begin
        slot = int'($urandom_range(7));
        ram[slot] = 8'($urandom);
      end
      step($urandom_range(99) == 0, $urandom_range(39) != 0);
    end
    step(1'b0, 1'b1);
    @(negedge clk);
    #1;

    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
